// File: rtl/stream_pkg.sv
// Shared types and constants for the stream-cipher init sequencer and its helpers.
// Latency: n/a (package only).
// Backpressure: n/a.
package stream_pkg;

  localparam int KEY_W       = 189;
  localparam int WORD_W      = 32;
  localparam int N_KEY_WORDS = 6;
  localparam int ROT_S       = 3;
  localparam int ROT_L       = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEED   = 2'd1,
    ST_WARMUP = 2'd2,
    ST_RUN    = 2'd3
  } state_e;

  // Rotate left by n (0 < n < WORD_W).
  function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] v, input int unsigned n);
    return (v << n) | (v >> (WORD_W - n));
  endfunction

endpackage

// File: rtl/seed_mix.sv
// Combinational key/IV mixing into the three chaotic-map seeds.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: key_lo = key bits [95:0]; iv = 32-bit IV; xp0/xs0/xl0 = piecewise, skew-tent, logistic seeds.
module seed_mix
  import stream_pkg::*;
(
  input  logic [3*WORD_W-1:0] key_lo,
  input  logic [WORD_W-1:0]   iv,
  output logic [WORD_W-1:0]   xp0,
  output logic [WORD_W-1:0]   xs0,
  output logic [WORD_W-1:0]   xl0
);

  assign xp0 = key_lo[WORD_W-1:0]          ^ iv;
  assign xs0 = key_lo[2*WORD_W-1:WORD_W]   ^ rotl(iv, ROT_S);
  assign xl0 = key_lo[3*WORD_W-1:2*WORD_W] ^ rotl(iv, ROT_L);

endmodule

// File: rtl/stream_init_ctrl.sv
// Stream-cipher init sequencer: key/IV capture, seed derivation, seed load, warm-up, keystream gating.
// Latency: seeds registered on start accept; SEED 1 cycle; WARMUP cycles; ks_valid trails iter_en by 1 cycle.
// Backpressure: consumer paces keystream with gen_en; writes and starts are dropped while busy.
// Ports: clk/rst (sync, active-high); key_we/key_addr/key_wdata and iv_we/iv_wdata host writes;
//        start init request; gen_en keystream request; Xp0/Xs0/Xl0 seeds; seed_load/iter_en/ks_valid
//        map control; busy (SEED|WARMUP); ready (RUN); start_err one-cycle reject pulse.
module stream_init_ctrl
  import stream_pkg::*;
#(
  parameter int WARMUP = 64,
  parameter int CW     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_we,
  input  logic [2:0]  key_addr,
  input  logic [31:0] key_wdata,
  input  logic        iv_we,
  input  logic [31:0] iv_wdata,
  input  logic        start,
  input  logic        gen_en,
  output logic [31:0] Xp0,
  output logic [31:0] Xs0,
  output logic [31:0] Xl0,
  output logic        seed_load,
  output logic        iter_en,
  output logic        ks_valid,
  output logic        busy,
  output logic        ready,
  output logic        start_err
);

  localparam int TOP_LSB = (N_KEY_WORDS - 1) * WORD_W;  // first bit of the short top word
  localparam int TOP_W   = KEY_W - TOP_LSB;             // 29 valid bits in word 5

  state_e                  state_q, state_d;
  logic [CW-1:0]           counter_q, counter_d;
  logic [KEY_W-1:0]        key_reg_q, key_reg_d;
  logic [N_KEY_WORDS-1:0]  key_mask_q, key_mask_d, key_mask_w;
  logic [WORD_W-1:0]       iv_reg_q, iv_reg_d;
  logic                    iv_ok_q, iv_ok_d, iv_ok_w;
  logic [WORD_W-1:0]       xp0_q, xp0_d, xs0_q, xs0_d, xl0_q, xl0_d;
  logic                    ks_valid_q, ks_valid_d;
  logic                    start_err_q, start_err_d;
  logic                    wr_open;
  logic                    start_ok;
  logic [WORD_W-1:0]       mix_xp0, mix_xs0, mix_xl0;

  // Upper key words are held for other consumers; nothing here reads them.
  logic unused_key_hi;
  assign unused_key_hi = ^key_reg_q[KEY_W-1:3*WORD_W];

  assign wr_open = (state_q == ST_IDLE) || (state_q == ST_RUN);

  // Host writes, then the start check against the post-write mask/iv_ok so a
  // write and start in the same cycle behave as write-then-start.
  always_comb begin
    key_reg_d  = key_reg_q;
    key_mask_w = key_mask_q;
    iv_reg_d   = iv_reg_q;
    iv_ok_w    = iv_ok_q;
    if (wr_open && key_we) begin
      for (int w = 0; w < N_KEY_WORDS - 1; w++) begin
        if (key_addr == 3'(w)) begin
          key_reg_d[w*WORD_W +: WORD_W] = key_wdata;
          key_mask_w[w]                 = 1'b1;
        end
      end
      if (key_addr == 3'(N_KEY_WORDS - 1)) begin
        key_reg_d[KEY_W-1:TOP_LSB]   = key_wdata[TOP_W-1:0];
        key_mask_w[N_KEY_WORDS-1]    = 1'b1;
      end
    end
    if (wr_open && iv_we) begin
      iv_reg_d = iv_wdata;
      iv_ok_w  = 1'b1;
    end
    start_ok   = wr_open && start && (key_mask_w == '1) && iv_ok_w;
    // A consumed start needs a fresh IV and a full key rewrite next time.
    key_mask_d = start_ok ? '0   : key_mask_w;
    iv_ok_d    = start_ok ? 1'b0 : iv_ok_w;
  end

  seed_mix u_seed_mix (
    .key_lo (key_reg_d[3*WORD_W-1:0]),
    .iv     (iv_reg_d),
    .xp0    (mix_xp0),
    .xs0    (mix_xs0),
    .xl0    (mix_xl0)
  );

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    xp0_d       = xp0_q;
    xs0_d       = xs0_q;
    xl0_d       = xl0_q;
    ks_valid_d  = 1'b0;
    start_err_d = 1'b0;
    seed_load   = 1'b0;
    iter_en     = 1'b0;

    if (start_ok) begin
      xp0_d = mix_xp0;
      xs0_d = mix_xs0;
      xl0_d = mix_xl0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_ok)   state_d     = ST_SEED;
        else if (start) start_err_d = 1'b1;
      end
      ST_SEED: begin
        seed_load   = 1'b1;
        counter_d   = CW'(WARMUP);
        state_d     = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
        start_err_d = start;
      end
      ST_WARMUP: begin
        iter_en     = 1'b1;
        counter_d   = counter_q - CW'(1);
        if (counter_q == CW'(1)) state_d = ST_RUN;
        start_err_d = start;
      end
      ST_RUN: begin
        iter_en    = gen_en;
        // A rekey kills the in-flight keystream word.
        ks_valid_d = gen_en && !start_ok;
        if (start_ok)   state_d     = ST_SEED;
        else if (start) start_err_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      counter_q   <= '0;
      key_reg_q   <= '0;
      key_mask_q  <= '0;
      iv_reg_q    <= '0;
      iv_ok_q     <= 1'b0;
      xp0_q       <= '0;
      xs0_q       <= '0;
      xl0_q       <= '0;
      ks_valid_q  <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      key_reg_q   <= key_reg_d;
      key_mask_q  <= key_mask_d;
      iv_reg_q    <= iv_reg_d;
      iv_ok_q     <= iv_ok_d;
      xp0_q       <= xp0_d;
      xs0_q       <= xs0_d;
      xl0_q       <= xl0_d;
      ks_valid_q  <= ks_valid_d;
      start_err_q <= start_err_d;
    end
  end

  assign Xp0       = xp0_q;
  assign Xs0       = xs0_q;
  assign Xl0       = xl0_q;
  assign ks_valid  = ks_valid_q;
  assign start_err = start_err_q;
  assign busy      = (state_q == ST_SEED) || (state_q == ST_WARMUP);
  assign ready     = (state_q == ST_RUN);

endmodule

// File: tb/tb_stream_init_ctrl.sv
// Bench for stream_init_ctrl: one WARMUP=64 and one WARMUP=0 instance share the same stimulus.
module tb_stream_init_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_we;
  logic [2:0]  key_addr;
  logic [31:0] key_wdata;
  logic        iv_we;
  logic [31:0] iv_wdata;
  logic        start;
  logic        gen_en;

  logic [31:0] xp0_o [2];
  logic [31:0] xs0_o [2];
  logic [31:0] xl0_o [2];
  logic        seed_o [2];
  logic        iter_o [2];
  logic        ksv_o [2];
  logic        busy_o [2];
  logic        ready_o [2];
  logic        serr_o [2];

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;
  int warm_cnt = 0;

  always #5 clk = ~clk;

  stream_init_ctrl #(.WARMUP(64), .CW(16)) u_dut_w64 (
    .clk(clk), .rst(rst), .key_we(key_we), .key_addr(key_addr), .key_wdata(key_wdata),
    .iv_we(iv_we), .iv_wdata(iv_wdata), .start(start), .gen_en(gen_en),
    .Xp0(xp0_o[0]), .Xs0(xs0_o[0]), .Xl0(xl0_o[0]), .seed_load(seed_o[0]),
    .iter_en(iter_o[0]), .ks_valid(ksv_o[0]), .busy(busy_o[0]), .ready(ready_o[0]),
    .start_err(serr_o[0])
  );

  stream_init_ctrl #(.WARMUP(0), .CW(16)) u_dut_w0 (
    .clk(clk), .rst(rst), .key_we(key_we), .key_addr(key_addr), .key_wdata(key_wdata),
    .iv_we(iv_we), .iv_wdata(iv_wdata), .start(start), .gen_en(gen_en),
    .Xp0(xp0_o[1]), .Xs0(xs0_o[1]), .Xl0(xl0_o[1]), .seed_load(seed_o[1]),
    .iter_en(iter_o[1]), .ks_valid(ksv_o[1]), .busy(busy_o[1]), .ready(ready_o[1]),
    .start_err(serr_o[1])
  );

  function automatic int warm_of(input int i);
    return (i == 0) ? 64 : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Timeline view: m_phase = cycles since the last accepted start (0 = none).
  // Phase 1 is the seed cycle, phases 2..W+1 warm-up, beyond that keystream.
  int          m_phase [2];
  logic [5:0]  m_wr    [2];
  logic [31:0] m_iv    [2];
  bit          m_ivok  [2];
  logic [31:0] m_key   [2][3];  // only words 0..2 reach the seeds
  logic [31:0] m_xp    [2];
  logic [31:0] m_xs    [2];
  logic [31:0] m_xl    [2];
  bit          m_ksv   [2];
  bit          m_serr  [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      automatic int          w        = warm_of(i);
      automatic bit          busy_now = (m_phase[i] >= 1) && (m_phase[i] <= w + 1);
      automatic bit          run_now  = m_phase[i] > w + 1;
      automatic logic [5:0]  wr       = m_wr[i];
      automatic logic [31:0] iv       = m_iv[i];
      automatic bit          ivok     = m_ivok[i];
      automatic logic [31:0] k0       = m_key[i][0];
      automatic logic [31:0] k1       = m_key[i][1];
      automatic logic [31:0] k2       = m_key[i][2];
      automatic bit          acc;
      if (rst) begin
        m_phase[i] <= 0;  m_wr[i] <= '0; m_iv[i] <= '0; m_ivok[i] <= 1'b0;
        m_key[i][0] <= '0; m_key[i][1] <= '0; m_key[i][2] <= '0;
        m_xp[i] <= '0; m_xs[i] <= '0; m_xl[i] <= '0; m_ksv[i] <= 1'b0; m_serr[i] <= 1'b0;
      end else begin
        if (!busy_now && key_we && key_addr < 3'd6) begin
          wr[key_addr] = 1'b1;
          if (key_addr == 3'd0) k0 = key_wdata;
          if (key_addr == 3'd1) k1 = key_wdata;
          if (key_addr == 3'd2) k2 = key_wdata;
        end
        if (!busy_now && iv_we) begin
          iv   = iv_wdata;
          ivok = 1'b1;
        end
        acc = start && !busy_now && (wr == 6'h3F) && ivok;
        m_ksv[i]  <= run_now && gen_en && !acc;
        m_serr[i] <= start && !acc;
        if (acc) begin
          m_xp[i]    <= k0 ^ iv;
          m_xs[i]    <= k1 ^ ((iv << 3) | (iv >> 29));
          m_xl[i]    <= k2 ^ ((iv << 2) | (iv >> 30));
          wr         = '0;
          ivok       = 1'b0;
          m_phase[i] <= 1;
        end else if (m_phase[i] >= 1 && m_phase[i] < 1000000) begin
          m_phase[i] <= m_phase[i] + 1;
        end
        m_wr[i] <= wr; m_iv[i] <= iv; m_ivok[i] <= ivok;
        m_key[i][0] <= k0; m_key[i][1] <= k1; m_key[i][2] <= k2;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        automatic int w  = warm_of(i);
        automatic int p  = m_phase[i];
        automatic bit eb = (p >= 1) && (p <= w + 1);
        automatic bit er = p > w + 1;
        chk($sformatf("seed_load[%0d]", i), 32'(seed_o[i]), 32'(p == 1));
        chk($sformatf("iter_en[%0d]", i),   32'(iter_o[i]), 32'((eb && p >= 2) || (er && gen_en)));
        chk($sformatf("ks_valid[%0d]", i),  32'(ksv_o[i]),  32'(m_ksv[i]));
        chk($sformatf("busy[%0d]", i),      32'(busy_o[i]), 32'(eb));
        chk($sformatf("ready[%0d]", i),     32'(ready_o[i]), 32'(er));
        chk($sformatf("start_err[%0d]", i), 32'(serr_o[i]), 32'(m_serr[i]));
        chk($sformatf("Xp0[%0d]", i), xp0_o[i], m_xp[i]);
        chk($sformatf("Xs0[%0d]", i), xs0_o[i], m_xs[i]);
        chk($sformatf("Xl0[%0d]", i), xl0_o[i], m_xl[i]);
      end
    end
  end

  always @(negedge clk) begin
    if (busy_o[0] && iter_o[0]) warm_cnt <= warm_cnt + 1;
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
    key_we = 1'b0; iv_we = 1'b0; start = 1'b0; gen_en = 1'b0;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic wr_key(input int a, input logic [31:0] d);
    key_we = 1'b1; key_addr = 3'(a); key_wdata = d;
    cyc();
  endtask

  task automatic wr_iv(input logic [31:0] d);
    iv_we = 1'b1; iv_wdata = d;
    cyc();
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
  endtask

  task automatic wait_ready0(input string nm);
    automatic bit got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      at_neg();
      if (ready_o[0]) begin
        got = 1'b1;
        break;
      end
    end
    chk(nm, 32'(got), 32'd1);
  endtask

  bit pat    [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  bit exp_ks [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    rst = 1'b1; key_we = 1'b0; key_addr = '0; key_wdata = '0;
    iv_we = 1'b0; iv_wdata = '0; start = 1'b0; gen_en = 1'b0;
    cyc();
    cmp_en = 1'b1;
    cyc();
    at_neg();
    chk("rst_Xp0", xp0_o[0], 32'h0);
    chk("rst_busy", 32'(busy_o[0]), 32'd0);
    chk("rst_ready_w0", 32'(ready_o[1]), 32'd0);
    rst = 1'b0;
    cyc();

    // Partial key: start must be refused.
    for (int a = 0; a < 5; a++) wr_key(a, 32'(32'h11111111 * (a + 1)));
    wr_key(6, 32'hFFFF_FFFF);
    wr_iv(32'h8000_0001);
    do_start();
    at_neg();
    chk("partial_start_err", 32'(serr_o[0]), 32'd1);
    chk("partial_no_seed", 32'(seed_o[0]), 32'd0);
    chk("partial_idle", 32'(busy_o[0]), 32'd0);

    // Complete the key, fresh IV, accepted start.
    wr_key(5, 32'h6666_6666);
    wr_iv(32'h8000_0001);
    warm_cnt = 0;
    do_start();
    at_neg();
    chk("seed_load", 32'(seed_o[0]), 32'd1);
    chk("Xp0_vec", xp0_o[0], 32'h9111_1110);
    chk("Xs0_vec", xs0_o[0], 32'h2222_222E);
    chk("Xl0_vec", xl0_o[0], 32'h3333_3335);
    chk("w0_seed_busy", 32'(busy_o[1]), 32'd1);
    cyc();
    at_neg();
    chk("w0_ready_2cyc", 32'(ready_o[1]), 32'd1);
    chk("w0_no_warm_iter", 32'(iter_o[1]), 32'd0);

    // Key write + start during warm-up: both dropped.
    key_we = 1'b1; key_addr = 3'd0; key_wdata = 32'hDEAD_BEEF; start = 1'b1;
    cyc();
    at_neg();
    chk("warm_start_err", 32'(serr_o[0]), 32'd1);
    wait_ready0("ready_timeout_1");
    chk("warm_cnt", 32'(warm_cnt), 32'd64);

    // Keystream pacing.
    @(posedge clk);
    #1;
    for (int j = 0; j < 5; j++) begin
      gen_en = pat[j];
      at_neg();
      chk($sformatf("pat_iter_%0d", j), 32'(iter_o[0]), 32'(pat[j]));
      chk($sformatf("pat_ks_%0d", j), 32'(ksv_o[0]), 32'(exp_ks[j]));
      @(posedge clk);
      #1;
    end
    gen_en = 1'b0;

    // Word 0 was dropped in warm-up, so its mask bit is still clear.
    for (int a = 1; a < 6; a++) wr_key(a, 32'(32'h11111111 * (a + 1)));
    wr_iv(32'h8000_0001);
    do_start();
    at_neg();
    chk("drop_mask_err", 32'(serr_o[0]), 32'd1);
    chk("drop_mask_noseed", 32'(seed_o[0]), 32'd0);
    wr_key(0, 32'h1111_1111);
    gen_en = 1'b1;
    do_start();
    at_neg();
    chk("rekey_seed", 32'(seed_o[0]), 32'd1);
    chk("rekey_Xp0", xp0_o[0], 32'h9111_1110);
    chk("rekey_ks_kill", 32'(ksv_o[0]), 32'd0);

    // Reset mid-warm-up.
    repeat (5) cyc();
    rst = 1'b1;
    cyc();
    at_neg();
    chk("mid_rst_busy", 32'(busy_o[0]), 32'd0);
    chk("mid_rst_iter", 32'(iter_o[0]), 32'd0);
    chk("mid_rst_Xs0", xs0_o[0], 32'h0);
    rst = 1'b0;
    wr_iv(32'h8000_0001);
    do_start();
    at_neg();
    chk("mask_cleared_err", 32'(serr_o[0]), 32'd1);

    // Full load, then rekey the WARMUP=0 instance in RUN with a new IV.
    for (int a = 0; a < 6; a++) wr_key(a, 32'(32'h11111111 * (a + 1)));
    wr_iv(32'h8000_0001);
    do_start();
    cyc();
    cyc();
    for (int a = 0; a < 6; a++) wr_key(a, 32'(32'h11111111 * (a + 1)));
    wr_iv(32'h1234_5678);
    gen_en = 1'b1;
    do_start();
    at_neg();
    chk("newiv_seed", 32'(seed_o[1]), 32'd1);
    chk("newiv_Xp0", xp0_o[1], 32'h0325_4769);
    chk("newiv_Xs0", xs0_o[1], 32'hB380_91E2);
    chk("newiv_Xl0", xl0_o[1], 32'h7BE2_6AD3);
    chk("newiv_ks_kill", 32'(ksv_o[1]), 32'd0);
    chk("newiv_w64_err", 32'(serr_o[0]), 32'd1);
    wait_ready0("ready_timeout_2");
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
